// File: rtl/except_pkg.sv
// except_pkg: shared codes, CP0 addresses, flag indices and state types for except_ctrl
package except_pkg;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam int F_IADEL = 0;
    localparam int F_RI    = 1;
    localparam int F_SYS   = 2;
    localparam int F_BP    = 3;
    localparam int F_OV    = 4;
    localparam int F_TR    = 5;
    localparam int F_DADEL = 6;
    localparam int F_DADES = 7;
    localparam int F_ERET  = 8;
    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;
    typedef enum logic [1:0] {BAD_NONE, BAD_PC, BAD_ADDR} bad_sel_t;
endpackage

// File: rtl/except_prio.sv
// except_prio: combinational priority encoder from interrupt + exception flags to code/bad-address select
module except_prio
    import except_pkg::*;
(
    input  logic        irq,
    input  logic [8:0]  exc,
    output logic        valid,
    output logic [31:0] code,
    output bad_sel_t    bad_sel,
    output logic        is_eret
);
    always_comb begin
        valid   = irq | (|exc);
        code    = irq          ? EXC_INT  :
                  exc[F_IADEL] ? EXC_ADEL :
                  exc[F_RI]    ? EXC_RI   :
                  exc[F_SYS]   ? EXC_SYS  :
                  exc[F_BP]    ? EXC_BP   :
                  exc[F_OV]    ? EXC_OV   :
                  exc[F_TR]    ? EXC_TR   :
                  exc[F_DADEL] ? EXC_ADEL :
                  exc[F_DADES] ? EXC_ADES :
                  exc[F_ERET]  ? EXC_ERET : 32'h0;
        bad_sel = irq                      ? BAD_NONE :
                  exc[F_IADEL]             ? BAD_PC   :
                  |exc[F_TR:F_RI]          ? BAD_NONE :
                  |exc[F_DADES:F_DADEL]    ? BAD_ADDR : BAD_NONE;
        is_eret = ~irq & ~(|exc[F_DADES:F_IADEL]) & exc[F_ERET];
    end
endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception/interrupt sequencer (IDLE -> DRAIN -> COMMIT) driving CP0, flush and PC redirect.
// Optional macro EXC_TIMER_INT_EN adds timer_int_i, ORed into Cause IP7.
module except_ctrl
    import except_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [8:0]  mem_exc_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_cp0_we_i,
    input  logic [4:0]  mem_cp0_waddr_i,
    input  logic [31:0] mem_cp0_wdata_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        bus_busy_i,
`ifdef EXC_TIMER_INT_EN
    input  logic        timer_int_i,
`endif
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);
    state_t      state, state_n;
    logic [31:0] status, cause, epc;
    logic        timer, irq, evt;
    logic        p_valid, p_eret;
    logic [31:0] p_code;
    bad_sel_t    p_bad_sel;
    logic [31:0] code_q, pc_q, bad_q, target_q;
    logic        ds_q;
`ifdef EXC_TIMER_INT_EN
    assign timer = timer_int_i;
`else
    assign timer = 1'b0;
`endif
    // Bypass an MTC0 in the same stage so masking and the ERET target see it.
    always_comb begin
        status = (mem_cp0_we_i && mem_cp0_waddr_i == CP0_STATUS) ? mem_cp0_wdata_i : cp0_status_i;
        epc    = (mem_cp0_we_i && mem_cp0_waddr_i == CP0_EPC) ? mem_cp0_wdata_i : cp0_epc_i;
        cause  = cp0_cause_i;
        cause[9:8] = (mem_cp0_we_i && mem_cp0_waddr_i == CP0_CAUSE) ? mem_cp0_wdata_i[9:8] : cp0_cause_i[9:8];
        cause[15]  = cp0_cause_i[15] | timer;
        irq = mem_valid_i & status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
    end
    except_prio u_prio (
        .irq     (irq),
        .exc     (mem_exc_i),
        .valid   (p_valid),
        .code    (p_code),
        .bad_sel (p_bad_sel),
        .is_eret (p_eret)
    );
    assign evt = ~rst & mem_valid_i & p_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            code_q   <= '0;
            pc_q     <= '0;
            ds_q     <= 1'b0;
            bad_q    <= '0;
            target_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && evt) begin
                code_q   <= p_code;
                pc_q     <= mem_pc_i;
                ds_q     <= mem_in_delayslot_i;
                bad_q    <= p_bad_sel == BAD_PC ? mem_pc_i : p_bad_sel == BAD_ADDR ? mem_addr_i : 32'h0;
                target_q <= p_eret ? epc : EXC_VECTOR;
            end
        end
    end
    always_comb begin
        state_n             = state;
        stall_o             = 1'b0;
        flush_o             = 1'b0;
        excepttype_o        = '0;
        current_inst_addr_o = '0;
        is_in_delayslot_o   = 1'b0;
        bad_addr_o          = '0;
        new_pc_o            = '0;
        case (state)
            IDLE: begin
                stall_o = evt;
                state_n = !evt ? IDLE : bus_busy_i ? DRAIN : COMMIT;
            end
            DRAIN: begin
                stall_o = 1'b1;
                state_n = bus_busy_i ? DRAIN : COMMIT;
            end
            COMMIT: begin
                excepttype_o        = code_q;
                current_inst_addr_o = pc_q;
                is_in_delayslot_o   = ds_q;
                bad_addr_o          = bad_q;
                flush_o             = 1'b1;
                new_pc_o            = target_q;
                state_n             = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
